// File: rtl/euler_pkg.sv
// Shared definitions for the Euler-12 triangle/divisor search.
//   DEF_WIDTH           default datapath width (values, indices, counts)
//   DEF_TIMEOUT_CYCLES  default bound on a single factor_count wait phase
//   state_t / S_*       sequencer state encoding
package euler_pkg;

    localparam int DEF_WIDTH          = 32;
    localparam int DEF_TIMEOUT_CYCLES = 65536;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_ISSUE    = 3'd1;
    localparam state_t S_WAIT_CLR = 3'd2;
    localparam state_t S_WAIT_SET = 3'd3;
    localparam state_t S_CHECK    = 3'd4;
    localparam state_t S_FINISH   = 3'd5;

endpackage

// File: rtl/tri_gen.sv
// Incremental triangle-number generator.
//   i_init  load n=1, T=1
//   i_step  n <= n+1, T <= T+(n+1)
//   o_n     current index n
//   o_t     current triangle number T(n)
//   o_ovf   1 when the next step T+(n+1) would not fit in WIDTH bits
module tri_gen
    import euler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_init,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_n,
    output logic [WIDTH-1:0] o_t,
    output logic             o_ovf
);

    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH:0]   w_next_sum;

    // One adder does both jobs: T+n+1 is the next triangle number and its
    // carry out is the overflow flag. n <= T always, so n+1 cannot wrap
    // without this sum also carrying.
    assign w_next_sum = {1'b0, r_t} + {1'b0, r_n} + {{WIDTH{1'b0}}, 1'b1};
    assign o_ovf      = w_next_sum[WIDTH];
    assign o_n        = r_n;
    assign o_t        = r_t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n <= '0;
            r_t <= '0;
        end else if (i_init) begin
            r_n <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_t <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (i_step) begin
            r_n <= r_n + {{(WIDTH-1){1'b0}}, 1'b1};
            r_t <= w_next_sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/triangle_divisor_search.sv
// Sequencer for the factor_count datapath: walks T(n)=n(n+1)/2 and stops at
// the first T(n) whose divisor count exceeds the latched threshold.
//   clk, rst_n            clock, async active-low reset
//   start, threshold      host request (sampled in IDLE), search bound
//   busy, done            search in progress, one-cycle end pulse
//   found, error          result flags, valid with done, held afterwards
//   tri_value/index       last evaluated T(n) and n
//   divisors              factor_count result for tri_value
//   fc_start, fc_value    request to factor_count
//   fc_done, fc_result    response from factor_count (level handshake)
module triangle_divisor_search
    import euler_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] threshold,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error,
    output logic [WIDTH-1:0] tri_value,
    output logic [WIDTH-1:0] tri_index,
    output logic [WIDTH-1:0] divisors,
    output logic             fc_start,
    output logic [WIDTH-1:0] fc_value,
    input  logic             fc_done,
    input  logic [WIDTH-1:0] fc_result
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [WIDTH-1:0] r_thresh;
    logic [WIDTH-1:0] r_tri_value;
    logic [WIDTH-1:0] r_tri_index;
    logic [WIDTH-1:0] r_divisors;
    logic             r_found;
    logic             r_error;

    logic             w_init;
    logic             w_step;
    logic             w_match;
    logic             w_timeout;
    logic [WIDTH-1:0] w_n;
    logic [WIDTH-1:0] w_t;
    logic             w_ovf;

    assign w_match   = (r_divisors > r_thresh);
    // Fires on the TIMEOUT_CYCLES-th cycle spent in a wait state.
    assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_init    = (r_state == S_IDLE) && start;
    assign w_step    = (r_state == S_CHECK) && !w_match && !w_ovf;

    tri_gen #(.WIDTH(WIDTH)) u_tri_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_init (w_init),
        .i_step (w_step),
        .o_n    (w_n),
        .o_t    (w_t),
        .o_ovf  (w_ovf)
    );

    // Decoded from state so they fall asynchronously with reset.
    // T only moves on CHECK->ISSUE, so it doubles as the held operand.
    assign busy      = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done      = (r_state == S_FINISH);
    assign fc_start  = (r_state == S_ISSUE);
    assign fc_value  = w_t;
    assign found     = r_found;
    assign error     = r_error;
    assign tri_value = r_tri_value;
    assign tri_index = r_tri_index;
    assign divisors  = r_divisors;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_thresh    <= '0;
            r_tri_value <= '0;
            r_tri_index <= '0;
            r_divisors  <= '0;
            r_found     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_thresh <= threshold;
                        r_found  <= 1'b0;
                        r_error  <= 1'b0;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_CLR;
                end
                S_WAIT_CLR: begin
                    // factor_count has no reset; a done level left over from
                    // the previous operand must clear before we trust it.
                    if (!fc_done) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_SET;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WAIT_SET: begin
                    if (fc_done) begin
                        r_divisors  <= fc_result;
                        r_tri_value <= w_t;
                        r_tri_index <= w_n;
                        r_state     <= S_CHECK;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_CHECK: begin
                    if (w_match) begin
                        r_found <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (w_ovf) begin
                        r_error <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_divisor_search.sv
// Directed bench: two instances (32-bit default timeout, 8-bit with a short
// timeout), each driven by a behavioural factor_count model.
module tb_triangle_divisor_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    // ---- instance A: WIDTH=32, default timeout ----
    logic        a_start = 1'b0;
    logic [31:0] a_thr   = '0;
    logic        a_busy, a_done, a_found, a_error, a_fc_start;
    logic [31:0] a_tri_value, a_tri_index, a_divisors, a_fc_value;
    logic        a_fc_done   = 1'b0;
    logic [31:0] a_fc_result = '0;
    int          a_cnt       = 0;

    triangle_divisor_search #(.WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .threshold(a_thr),
        .busy(a_busy), .done(a_done), .found(a_found), .error(a_error),
        .tri_value(a_tri_value), .tri_index(a_tri_index), .divisors(a_divisors),
        .fc_start(a_fc_start), .fc_value(a_fc_value),
        .fc_done(a_fc_done), .fc_result(a_fc_result)
    );

    // ---- instance B: WIDTH=8, TIMEOUT_CYCLES=64 ----
    logic       b_start = 1'b0;
    logic [7:0] b_thr   = '0;
    logic       b_busy, b_done, b_found, b_error, b_fc_start;
    logic [7:0] b_tri_value, b_tri_index, b_divisors, b_fc_value;
    logic       b_fc_done   = 1'b0;
    logic [7:0] b_fc_result = '0;
    int         b_cnt       = 0;
    bit         b_hang      = 1'b0;

    triangle_divisor_search #(.WIDTH(8), .TIMEOUT_CYCLES(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .threshold(b_thr),
        .busy(b_busy), .done(b_done), .found(b_found), .error(b_error),
        .tri_value(b_tri_value), .tri_index(b_tri_index), .divisors(b_divisors),
        .fc_start(b_fc_start), .fc_value(b_fc_value),
        .fc_done(b_fc_done), .fc_result(b_fc_result)
    );

    localparam int LAT = 20;

    function automatic longint ndiv(input longint v);
        longint c = 0;
        for (longint d = 1; d * d <= v; d++)
            if (v % d == 0) c += (d * d == v) ? 1 : 2;
        return c;
    endfunction

    // factor_count models: no reset, restart on every fc_start
    always @(posedge clk) begin
        if (a_fc_start) begin
            a_fc_done   <= 1'b0;
            a_cnt       <= LAT;
            a_fc_result <= 32'(ndiv(longint'(a_fc_value)));
        end else if (a_cnt > 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 1) a_fc_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (b_fc_start) begin
            b_fc_done   <= 1'b0;
            b_cnt       <= b_hang ? 0 : LAT;
            b_fc_result <= 8'(ndiv(longint'(b_fc_value)));
        end else if (b_cnt > 0) begin
            b_cnt <= b_cnt - 1;
            if (b_cnt == 1) b_fc_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Start a search on A and wait for done. With poke set, extra start
    // pulses (threshold 0) are driven while busy; they must be ignored.
    task automatic run_a(input logic [31:0] thr, input bit poke, output int pulses);
        int cyc = 0;
        pulses = 0;
        @(negedge clk); a_thr = thr; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        chk("a_busy_lat", 64'(a_busy), 64'd1);
        while (!a_done && cyc < 20000) begin
            if (a_fc_start) pulses++;
            if (poke && (cyc == 3 || cyc == 40 || cyc == 100)) begin
                a_start = 1'b1; a_thr = '0;
            end else a_start = 1'b0;
            @(negedge clk); cyc++;
        end
        a_start = 1'b0;
        if (!a_done) chk("a_done_timeout", 64'd0, 64'd1);
        chk("a_busy_at_done", 64'(a_busy), 64'd0);
        @(negedge clk);
        chk("a_done_pulse", 64'(a_done), 64'd0);
    endtask

    task automatic run_b(input logic [7:0] thr);
        int cyc = 0;
        @(negedge clk); b_thr = thr; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        while (!b_done && cyc < 5000) begin
            @(negedge clk); cyc++;
        end
        if (!b_done) chk("b_done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int p;
        int cyc;

        // reset state
        #1;
        chk("rst_busy",  64'(a_busy), 64'd0);
        chk("rst_done",  64'(a_done), 64'd0);
        chk("rst_fcst",  64'(a_fc_start), 64'd0);
        chk("rst_fcval", 64'(a_fc_value), 64'd0);
        chk("rst_tri",   64'(a_tri_value), 64'd0);
        chk("rst_b_err", 64'(b_error), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // 1: threshold 5 -> 28 (n=7), 6 divisors, 7 requests
        run_a(32'd5, 1'b0, p);
        chk("t1_found", 64'(a_found), 64'd1);
        chk("t1_error", 64'(a_error), 64'd0);
        chk("t1_value", 64'(a_tri_value), 64'd28);
        chk("t1_index", 64'(a_tri_index), 64'd7);
        chk("t1_div",   64'(a_divisors), 64'd6);
        chk("t1_pulses", 64'(p), 64'd7);

        // 2: threshold 0 -> n=1 matches at once
        run_a(32'd0, 1'b0, p);
        chk("t2_found", 64'(a_found), 64'd1);
        chk("t2_value", 64'(a_tri_value), 64'd1);
        chk("t2_index", 64'(a_tri_index), 64'd1);
        chk("t2_div",   64'(a_divisors), 64'd1);

        // 3: threshold 100 -> 73920 (n=384), 112 divisors
        run_a(32'd100, 1'b0, p);
        chk("t3_found", 64'(a_found), 64'd1);
        chk("t3_value", 64'(a_tri_value), 64'd73920);
        chk("t3_index", 64'(a_tri_index), 64'd384);
        chk("t3_div",   64'(a_divisors), 64'd112);

        // 4: 8-bit, threshold all-ones -> overflow after T(22)=253
        run_b(8'd255);
        chk("t4_error", 64'(b_error), 64'd1);
        chk("t4_found", 64'(b_found), 64'd0);
        chk("t4_index", 64'(b_tri_index), 64'd22);
        chk("t4_value", 64'(b_tri_value), 64'd253);
        @(negedge clk);

        // 5: model never answers -> error 64 cycles into WAIT_SET
        // (ISSUE + WAIT_CLR + 64 = 66 edges from fc_start to done)
        b_hang = 1'b1;
        b_thr = 8'd255; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        cyc = 0;
        while (!b_fc_start && cyc < 10) begin @(negedge clk); cyc++; end
        cyc = 0;
        while (!b_done && cyc < 500) begin @(negedge clk); cyc++; end
        chk("t5_cycles", 64'(cyc), 64'd66);
        chk("t5_error",  64'(b_error), 64'd1);
        chk("t5_found",  64'(b_found), 64'd0);
        b_hang = 1'b0;

        // 6: reset mid-search at n=50, then a clean search with pokes
        @(negedge clk); a_thr = 32'd100; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        cyc = 0;
        while (!(a_fc_start && a_tri_index == 32'd50) && cyc < 5000) begin
            @(negedge clk); cyc++;
        end
        chk("t6_reached50", 64'(a_tri_index), 64'd50);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_fcst_async", 64'(a_fc_start), 64'd0);
        chk("t6_busy",  64'(a_busy), 64'd0);
        chk("t6_fcval", 64'(a_fc_value), 64'd0);
        chk("t6_index", 64'(a_tri_index), 64'd0);
        chk("t6_div",   64'(a_divisors), 64'd0);
        @(negedge clk); @(negedge clk);
        chk("t6_found_rst", 64'(a_found), 64'd0);
        rst_n = 1'b1;
        run_a(32'd5, 1'b1, p);
        chk("t6_found", 64'(a_found), 64'd1);
        chk("t6_value", 64'(a_tri_value), 64'd28);
        chk("t6_index2", 64'(a_tri_index), 64'd7);
        chk("t6_pulses", 64'(p), 64'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
